// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues credit-limited word requests,
// buffers responses with their PCs and hands them to decode; redirects flush everything.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_gnt,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  input  logic        i_instr_ready,
  output logic [31:0] o_instr_data,
  output logic [31:0] o_instr_pc,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_fetch_err
);

  // state  | meaning
  // BOOT   | first cycle after reset release, no request issued
  // RUN    | normal fetch; flushes are handled by the discard counter
  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  state_t r_state;
  state_t w_state_next;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_discard;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [31:0]   r_mem_data [DEPTH];
  logic [31:0]   r_mem_pc   [DEPTH];

  logic          w_credit;
  logic          w_gnt;
  logic          w_rv;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_outstanding_next;
  logic [31:0]   w_redirect_aligned;

  assign w_credit = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_W;
  assign w_gnt    = o_imem_req & i_imem_gnt;
  // A response with nothing outstanding is a protocol violation and is dropped.
  assign w_rv     = i_imem_rvalid & (r_outstanding != '0);
  assign w_drop   = w_rv & (r_discard != '0);
  assign w_push   = w_rv & (r_discard == '0) & ~i_redirect;
  assign w_pop    = o_instr_valid & i_instr_ready & ~i_redirect;

  assign w_redirect_aligned = {i_redirect_pc[31:2], 2'b00};

  always_comb begin
    w_outstanding_next = r_outstanding;
    if (w_gnt && !w_rv) begin
      w_outstanding_next = r_outstanding + 1'b1;
    end else if (!w_gnt && w_rv) begin
      w_outstanding_next = r_outstanding - 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_imem_req   = 1'b0;
    case (r_state)
      S_BOOT: begin
        w_state_next = S_RUN;
      end
      S_RUN: begin
        o_imem_req = w_credit & ~i_redirect;
      end
      default: begin
        w_state_next = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fetch_pc    <= RESET_ADDR;
      r_resp_pc     <= RESET_ADDR;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (i_redirect) begin
        // Everything still in flight after this cycle belongs to the old stream.
        r_discard  <= w_outstanding_next;
        r_fetch_pc <= w_redirect_aligned;
        r_resp_pc  <= w_redirect_aligned;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_drop) begin
          r_discard <= r_discard - 1'b1;
        end
        if (w_gnt) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (w_push) begin
          r_wptr    <= r_wptr + 1'b1;
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Storage needs no reset: the head is only visible while the FIFO is non-empty.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem_data[r_wptr] <= i_imem_rdata;
      r_mem_pc[r_wptr]   <= r_resp_pc;
    end
  end

  assign o_imem_addr   = r_fetch_pc;
  assign o_instr_valid = (r_count != '0);
  assign o_instr_data  = o_instr_valid ? r_mem_data[r_rptr] : 32'h0;
  assign o_instr_pc    = o_instr_valid ? r_mem_pc[r_rptr] : 32'h0;
  assign o_fetch_err   = i_redirect & (i_redirect_pc[1:0] != 2'b00) & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (!(i_imem_rvalid && (r_outstanding == '0)))
        else $error("imem_rvalid with no outstanding request");
      assert (r_discard <= r_outstanding)
        else $error("discard count exceeds outstanding count");
      assert (({1'b0, r_outstanding} + {1'b0, r_count}) <= DEPTH_W)
        else $error("outstanding plus buffered exceeds DEPTH");
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: in-order memory model with programmable
// latency/stalls, a reference FIFO model, a redirect vector table and hand sequences.
module tb_instr_fetch_unit;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_A  = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  instr_fetch_unit #(.RESET_ADDR(RST_A), .DEPTH(DEPTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_gnt    (imem_gnt),
    .i_imem_rvalid (imem_rvalid),
    .i_imem_rdata  (imem_rdata),
    .o_instr_valid (instr_valid),
    .i_instr_ready (instr_ready),
    .o_instr_data  (instr_data),
    .o_instr_pc    (instr_pc),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  typedef struct {
    logic [31:0] target;
    logic        exp_err;
    logic [31:0] exp_addr;
  } rd_vec_t;

  int          checks;
  int          errors;
  mreq_t       memq[$];
  logic [31:0] fifo_m[$];
  int          disc_m;
  logic [31:0] exp_fetch;
  bit          run_m;
  int          cyc;
  int          lat;
  bit          stall_en;
  bit          rnd_ready;
  rd_vec_t     vecs[6];

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1357};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: check outputs against the model, update the model with this
  // cycle's handshakes, then drive the next cycle's inputs after the falling edge.
  task automatic tick();
    bit          g;
    bit          rv;
    bit          pop;
    bit          redir;
    logic [31:0] al;
    logic [31:0] a;
    mreq_t       m;
    #1;
    redir = redirect;
    al    = {redirect_pc[31:2], 2'b00};
    chk("imem_req", imem_req, run_m && !redir && ((memq.size() + fifo_m.size()) < DEPTH));
    if (imem_req) chk("imem_addr", imem_addr, exp_fetch);
    chk("instr_valid", instr_valid, fifo_m.size() != 0);
    if (fifo_m.size() != 0) begin
      chk("instr_pc", instr_pc, fifo_m[0]);
      chk("instr_data", instr_data, mdata(fifo_m[0]));
    end
    chk("fetch_err", fetch_err, redir && (redirect_pc[1:0] != 2'b00));
    g   = imem_req && imem_gnt;
    rv  = imem_rvalid;
    pop = instr_valid && instr_ready;
    a   = 32'h0;
    if (rv && memq.size() != 0) begin
      m = memq.pop_front();
      a = m.addr;
    end
    if (pop && !redir && fifo_m.size() != 0) void'(fifo_m.pop_front());
    if (rv) begin
      if (disc_m > 0) disc_m--;
      else if (!redir) fifo_m.push_back(a);
    end
    if (g) begin
      m.addr = imem_addr;
      m.due  = cyc + lat;
      memq.push_back(m);
      exp_fetch += 32'd4;
    end
    if (redir) begin
      fifo_m.delete();
      disc_m    = memq.size();
      exp_fetch = al;
    end
    @(posedge clk);
    cyc++;
    run_m = 1'b1;
    @(negedge clk);
    redirect = 1'b0;
    if (memq.size() != 0 && memq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mdata(memq[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
    end
    imem_gnt = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (rnd_ready) instr_ready = ($urandom_range(0, 1) != 0);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    imem_rvalid = 1'b0;
    redirect    = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, RST_A);
    chk("rst_valid", instr_valid, 0);
    chk("rst_data", instr_data, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_err", fetch_err, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    memq.delete();
    fifo_m.delete();
    disc_m    = 0;
    exp_fetch = RST_A;
    run_m     = 1'b0;
    #1;
    chk("boot_req", imem_req, 0);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    for (int i = 0; i < 30 && !instr_valid; i++) tick();
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for instr_valid, required pc=%h", name, exp_pc);
    end else begin
      chk(name, instr_pc, exp_pc);
    end
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 1'b0, 32'h0000_0100};
    vecs[1] = '{32'h0000_0102, 1'b1, 32'h0000_0100};
    vecs[2] = '{32'h0000_0203, 1'b1, 32'h0000_0200};
    vecs[3] = '{32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFC};
    vecs[4] = '{32'h0000_0041, 1'b1, 32'h0000_0040};
    vecs[5] = '{32'h0000_0000, 1'b0, 32'h0000_0000};

    checks      = 0;
    errors      = 0;
    cyc         = 0;
    lat         = 1;
    stall_en    = 1'b0;
    rnd_ready   = 1'b0;
    disc_m      = 0;
    run_m       = 1'b0;
    exp_fetch   = RST_A;
    rst         = 1'b1;
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    do_reset();

    // Decode stalled: FIFO fills to DEPTH and requests stop.
    repeat (10) tick();
    chk("full_req", imem_req, 0);
    chk("full_head", instr_pc, 32'h0);
    instr_ready = 1'b1;
    chk("drain_pc0", instr_pc, 32'h0);
    tick();
    chk("drain_pc1", instr_pc, 32'h4);
    tick();
    wait_valid("drain_pc2", 32'h8);
    repeat (20) tick();

    // Redirect vectors with a 2-cycle memory.
    lat = 2;
    foreach (vecs[i]) begin
      redirect    = 1'b1;
      redirect_pc = vecs[i].target;
      #1;
      chk("rd_err", fetch_err, vecs[i].exp_err);
      chk("rd_req_low", imem_req, 0);
      tick();
      chk("rd_addr", imem_addr, vecs[i].exp_addr);
      wait_valid("rd_first_pc", vecs[i].exp_addr);
      repeat (6) tick();
    end

    // Redirect with two requests in flight: both late responses are dropped.
    lat = 3;
    for (int i = 0; i < 20 && memq.size() != 2; i++) tick();
    chk("two_outstanding", memq.size(), 2);
    do_redirect(32'h0000_0100);
    chk("late_addr", imem_addr, 32'h0000_0100);
    wait_valid("late_first_pc", 32'h0000_0100);
    repeat (6) tick();

    // Redirect in the same cycle as a pop and a returning word.
    lat = 1;
    for (int i = 0; i < 30 && !(instr_valid && imem_rvalid); i++) tick();
    chk("pop_rv_same", instr_valid && imem_rvalid, 1);
    do_redirect(32'h0000_0300);
    chk("prv_addr", imem_addr, 32'h0000_0300);
    wait_valid("prv_first_pc", 32'h0000_0300);

    // Random grant stalls and decode backpressure, wrapping through 0xFFFFFFFC.
    lat       = 3;
    stall_en  = 1'b1;
    rnd_ready = 1'b1;
    do_redirect(32'hFFFF_FFF0);
    repeat (60) tick();
    do_reset();
    repeat (40) tick();
    repeat (3) begin
      do_redirect($urandom);
      repeat (25) tick();
    end

    stall_en    = 1'b0;
    rnd_ready   = 1'b0;
    instr_ready = 1'b1;
    repeat (20) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
